// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode for the load/store unit.
// LSU_MISALIGN_TRAP_EN (optional define) turns misaligned half/word accesses into faults.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Legal RV32I load/store encodings; everything else is faulted.
    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        else
            return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                   (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // Halfword needs addr[0]==0, word needs addr[1:0]==0 (loads and stores share funct3[1:0]).
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane-0 datapath: load extract/extend and sub-word store merge.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    // Extract the addressed byte/half from lane 0 and extend it.
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{rdata[7]}}, rdata[7:0]};
            F3_LH:   load_data = {{16{rdata[15]}}, rdata[15:0]};
            F3_LBU:  load_data = {24'd0, rdata[7:0]};
            F3_LHU:  load_data = {16'd0, rdata[15:0]};
            default: load_data = rdata;
        endcase
    end

    // Overlay the store bytes onto the word read back from memory.
    always_comb begin
        merged = wdata;
        case (funct3)
            F3_SB:   merged = {rdata[31:8], wdata[7:0]};
            F3_SH:   merged = {rdata[31:16], wdata[15:0]};
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data_mem. One request in flight; SB/SH are
// read-modify-write because data_mem always writes a full 4-byte word.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned LH/LHU/SH/LW/SW instead of performing them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Compare one bit wider than the address so a top-of-space address cannot wrap past the check.
    localparam logic [ADDR_W:0] MAX_ADDR = (ADDR_W+1)'(MEM_BYTES - 4);

    lsu_state_e  state;
    logic [2:0]  lat_f3;
    logic [31:0] lat_wdata;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        accept;
    logic        req_bad;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_bad = !f3_legal(req_we, req_funct3) || ({1'b0, req_addr} > MAX_ADDR) ||
                     misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_bad = !f3_legal(req_we, req_funct3) || ({1'b0, req_addr} > MAX_ADDR);
`endif

    lsu_byte_lane u_lane (
        .funct3    (lat_f3),
        .rdata     (mem_rdata),
        .wdata     (lat_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // Request FSM; all memory and response outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lat_f3    <= '0;
            lat_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_f3    <= req_funct3;
                        lat_wdata <= req_wdata;
                        mem_addr  <= req_addr;
                        if (req_bad) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (!req_we) begin
                            state    <= S_LOAD;
                            mem_read <= 1'b1;
                        end else if (req_funct3 == F3_SW) begin
                            state     <= S_WRITE;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= S_RMW_RD;
                            mem_read <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    mem_read  <= 1'b0;
                    rsp_rdata <= load_data;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b1;
                    mem_wdata <= merged;
                    state     <= S_WRITE;
                end
                S_WRITE: begin
                    mem_write <= 1'b0;
                    mem_wdata <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
